// File: rtl/mem_cache_pkg.sv
// Shared FSM encoding and address-field width helpers for the data cache.
// Field widths depend on the cache parameters, so they are exposed as constant functions.
package mem_cache_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVICT,
    ST_FILL,
    ST_FLUSH
  } cache_state_t;

  function automatic int offset_bits(input int log2_line);
    return log2_line - 3;
  endfunction

  function automatic int tag_bits(input int log2_line, input int log2_depth);
    return ADDR_W - offset_bits(log2_line) - log2_depth;
  endfunction

endpackage

// File: rtl/mem_plru.sv
// Victim selection (lowest invalid way, else tree pseudo-LRU) and PLRU touch update for one set.
// Tree nodes are heap-numbered from 1; a node bit of 1 points the victim walk to the right subtree.
module mem_plru #(
  parameter int LOG2NUMWAYS = 1,
  localparam int NW = 1 << LOG2NUMWAYS,
  localparam int PW = (NW > 1) ? NW - 1 : 1,
  localparam int WW = (LOG2NUMWAYS > 0) ? LOG2NUMWAYS : 1
) (
  input  logic [PW-1:0] i_bits,
  input  logic [NW-1:0] i_valid,
  input  logic [WW-1:0] i_touch_way,
  output logic [WW-1:0] o_victim,
  output logic [PW-1:0] o_bits_next
);

  always_comb begin
    int   node;
    logic found;
    o_victim    = '0;
    o_bits_next = i_bits;
    found       = 1'b0;
    node        = 1;

    for (int w = NW - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        o_victim = WW'(w);
        found    = 1'b1;
      end
    end

    if (!found && NW > 1) begin
      for (int l = 0; l < LOG2NUMWAYS; l++) begin
        node = 2 * node + (i_bits[node-1] ? 1 : 0);
      end
      o_victim = WW'(node - NW);
    end

    // touching a way flips every node on its path to point away from it
    node = 1;
    for (int l = LOG2NUMWAYS - 1; l >= 0; l--) begin
      o_bits_next[node-1] = ~i_touch_way[l];
      node = 2 * node + (i_touch_way[l] ? 1 : 0);
    end
  end

endmodule

// File: rtl/mem_dcache_sa.sv
// Set-associative write-back data cache with line-wide bus, PLRU replacement and full flush.
// Requests are registered on acceptance; a miss evicts/fills then replays the lookup.
module mem_dcache_sa
  import mem_cache_pkg::*;
#(
  parameter int LOG2CACHELINESIZE = 7,
  parameter int LOG2CACHEDEPTH    = 6,
  parameter int LOG2NUMWAYS       = 1
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [31:0]                           bus_address,
  input  logic                                  bus_en,
  input  logic                                  bus_wren,
  input  logic [(1<<LOG2CACHELINESIZE)-1:0]     bus_writedata,
  input  logic [(1<<LOG2CACHELINESIZE)/8-1:0]   bus_byteen,
  output logic [31:0]                           bus_readdata,
  output logic [(1<<LOG2CACHELINESIZE)-1:0]     bus_readdata_line,
  output logic                                  bus_wait,
  input  logic                                  bus_flush,
  output logic                                  bus_flushdone,
  output logic [31:0]                           mem_address,
  output logic [(1<<LOG2CACHELINESIZE)-1:0]     mem_writedata,
  input  logic [(1<<LOG2CACHELINESIZE)-1:0]     mem_readdata,
  output logic                                  mem_rden,
  output logic                                  mem_wren,
  input  logic                                  mem_ack,
  output logic                                  cache_hit,
  output logic                                  cache_miss
);

  localparam int LINE_W = 1 << LOG2CACHELINESIZE;
  localparam int BE_W   = LINE_W / 8;
  localparam int OFF_W  = offset_bits(LOG2CACHELINESIZE);
  localparam int IDX_W  = LOG2CACHEDEPTH;
  localparam int TAG_W  = tag_bits(LOG2CACHELINESIZE, LOG2CACHEDEPTH);
  localparam int DEPTH  = 1 << IDX_W;
  localparam int NW     = 1 << LOG2NUMWAYS;
  localparam int PW     = (NW > 1) ? NW - 1 : 1;
  localparam int WW     = (LOG2NUMWAYS > 0) ? LOG2NUMWAYS : 1;

  cache_state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic              r_wren;
  logic [LINE_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_byteen;

  logic [LINE_W-1:0] r_data  [NW][DEPTH];
  logic [TAG_W-1:0]  r_tag   [NW][DEPTH];
  logic [DEPTH-1:0]  r_valid [NW];
  logic [DEPTH-1:0]  r_dirty [NW];
  logic [PW-1:0]     r_plru  [DEPTH];

  logic              r_flush_pend;
  logic [WW-1:0]     r_victim;
  logic [IDX_W-1:0]  r_fl_set;
  logic [WW-1:0]     r_fl_way;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic [WW-1:0]     w_hit_way;
  logic [LINE_W-1:0] w_hit_line;
  logic [LINE_W-1:0] w_merged;
  logic [NW-1:0]     w_valid_set;
  logic [WW-1:0]     w_victim;
  logic [PW-1:0]     w_plru_next;
  logic              w_fl_dirty;
  logic              w_fl_done;
  logic              w_fl_last;
  logic              w_accept;
  logic              w_flush_start;

  assign w_idx = r_addr[OFF_W +: IDX_W];
  assign w_tag = r_addr[ADDR_W-1 -: TAG_W];

  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_valid_set = '0;
    for (int w = 0; w < NW; w++) begin
      w_valid_set[w] = r_valid[w][w_idx];
      if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(w);
      end
    end
  end

  assign w_hit_line        = r_data[w_hit_way][w_idx];
  assign bus_readdata_line = w_hit_line;

  if (OFF_W > 2) begin : g_word_sel
    assign bus_readdata = w_hit_line[int'(r_addr[OFF_W-1:2]) * WORD_W +: WORD_W];
  end else begin : g_word_only
    assign bus_readdata = w_hit_line[WORD_W-1:0];
  end

  always_comb begin
    w_merged = w_hit_line;
    for (int b = 0; b < BE_W; b++) begin
      if (r_byteen[b]) w_merged[b*8 +: 8] = r_wdata[b*8 +: 8];
    end
  end

  mem_plru #(.LOG2NUMWAYS(LOG2NUMWAYS)) u_plru (
    .i_bits      (r_plru[w_idx]),
    .i_valid     (w_valid_set),
    .i_touch_way (w_hit_way),
    .o_victim    (w_victim),
    .o_bits_next (w_plru_next)
  );

  assign w_fl_dirty = r_valid[r_fl_way][r_fl_set] & r_dirty[r_fl_way][r_fl_set];
  assign w_fl_done  = !w_fl_dirty || mem_ack;
  assign w_fl_last  = (r_fl_set == {IDX_W{1'b1}}) && (r_fl_way == WW'(NW - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_flush_start = 1'b0;
    bus_wait      = 1'b0;
    bus_flushdone = 1'b0;
    cache_hit     = 1'b0;
    cache_miss    = 1'b0;
    mem_rden      = 1'b0;
    mem_wren      = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus_flush || r_flush_pend) begin
          w_flush_start = 1'b1;
          w_state_nxt   = ST_FLUSH;
        end else if (bus_en) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (w_hit) begin
          cache_hit = 1'b1;
          if (bus_en) w_accept = 1'b1;
          else        w_state_nxt = ST_IDLE;
        end else begin
          cache_miss  = 1'b1;
          bus_wait    = 1'b1;
          w_state_nxt = (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) ? ST_EVICT : ST_FILL;
        end
      end
      ST_EVICT: begin
        bus_wait      = 1'b1;
        mem_wren      = 1'b1;
        mem_address   = {r_tag[r_victim][w_idx], w_idx, {OFF_W{1'b0}}};
        mem_writedata = r_data[r_victim][w_idx];
        if (mem_ack) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        bus_wait    = 1'b1;
        mem_rden    = 1'b1;
        mem_address = {w_tag, w_idx, {OFF_W{1'b0}}};
        if (mem_ack) w_state_nxt = ST_LOOKUP;
      end
      ST_FLUSH: begin
        bus_wait = 1'b1;
        if (w_fl_dirty) begin
          mem_wren      = 1'b1;
          mem_address   = {r_tag[r_fl_way][r_fl_set], r_fl_set, {OFF_W{1'b0}}};
          mem_writedata = r_data[r_fl_way][r_fl_set];
        end
        if (w_fl_done && w_fl_last) begin
          bus_flushdone = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // valid/dirty/PLRU and control state; line data and tags need no reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_flush_pend <= 1'b0;
      r_victim     <= '0;
      r_fl_set     <= '0;
      r_fl_way     <= '0;
      for (int w = 0; w < NW; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
      for (int s = 0; s < DEPTH; s++) r_plru[s] <= '0;
    end else begin
      if (w_flush_start) begin
        r_flush_pend <= 1'b0;
        r_fl_set     <= '0;
        r_fl_way     <= '0;
      end else if (bus_flush && r_state != ST_IDLE) begin
        r_flush_pend <= 1'b1;
      end
      case (r_state)
        ST_LOOKUP: begin
          if (w_hit) begin
            r_plru[w_idx] <= w_plru_next;
            if (r_wren) r_dirty[w_hit_way][w_idx] <= 1'b1;
          end else begin
            r_victim <= w_victim;
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            r_valid[r_victim][w_idx] <= 1'b1;
            r_dirty[r_victim][w_idx] <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (w_fl_done) begin
            r_valid[r_fl_way][r_fl_set] <= 1'b0;
            r_dirty[r_fl_way][r_fl_set] <= 1'b0;
            if (r_fl_way == WW'(NW - 1)) begin
              r_fl_way <= '0;
              r_fl_set <= r_fl_set + 1'b1;
            end else begin
              r_fl_way <= r_fl_way + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr   <= bus_address;
      r_wren   <= bus_wren;
      r_wdata  <= bus_writedata;
      r_byteen <= bus_byteen;
    end
    if (r_state == ST_LOOKUP && w_hit && r_wren) r_data[w_hit_way][w_idx] <= w_merged;
    if (r_state == ST_FILL && mem_ack) begin
      r_data[r_victim][w_idx] <= mem_readdata;
      r_tag[r_victim][w_idx]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_mem_dcache_sa.sv
// Directed bench for mem_dcache_sa at default parameters (128-bit lines, 64 sets, 2 ways).
// A responder acks every memory request on its second cycle and keeps written-back lines.
module tb_mem_dcache_sa;

  logic         clk;
  logic         resetn;
  logic [31:0]  bus_address;
  logic         bus_en;
  logic         bus_wren;
  logic [127:0] bus_writedata;
  logic [15:0]  bus_byteen;
  logic [31:0]  bus_readdata;
  logic [127:0] bus_readdata_line;
  logic         bus_wait;
  logic         bus_flush;
  logic         bus_flushdone;
  logic [31:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_rden;
  logic         mem_wren;
  logic         mem_ack;
  logic         cache_hit;
  logic         cache_miss;

  int n_cmp;
  int n_bad;
  int rd_cnt;
  int wr_cnt;
  int overlap;
  int req_cnt;
  bit ack_en;
  logic [31:0]  last_rd_addr;
  logic [127:0] last_wr_data;
  logic [31:0]  wr_log[$];
  logic [127:0] mem_store [logic [31:0]];

  mem_dcache_sa dut (
    .clk               (clk),
    .resetn            (resetn),
    .bus_address       (bus_address),
    .bus_en            (bus_en),
    .bus_wren          (bus_wren),
    .bus_writedata     (bus_writedata),
    .bus_byteen        (bus_byteen),
    .bus_readdata      (bus_readdata),
    .bus_readdata_line (bus_readdata_line),
    .bus_wait          (bus_wait),
    .bus_flush         (bus_flush),
    .bus_flushdone     (bus_flushdone),
    .mem_address       (mem_address),
    .mem_writedata     (mem_writedata),
    .mem_readdata      (mem_readdata),
    .mem_rden          (mem_rden),
    .mem_wren          (mem_wren),
    .mem_ack           (mem_ack),
    .cache_hit         (cache_hit),
    .cache_miss        (cache_miss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] fill_line(input logic [31:0] a);
    return {a + 32'd3, a + 32'd2, a + 32'd1, a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory responder
  initial begin
    mem_ack      = 1'b0;
    mem_readdata = '0;
    req_cnt      = 0;
    forever begin
      @(negedge clk);
      if ((mem_rden || mem_wren) && ack_en) begin
        if (req_cnt == 1) begin
          mem_ack      = 1'b1;
          mem_readdata = mem_store.exists(mem_address) ? mem_store[mem_address] : fill_line(mem_address);
          if (mem_wren) mem_store[mem_address] = mem_writedata;
          req_cnt      = 0;
        end else begin
          mem_ack = 1'b0;
          req_cnt = 1;
        end
      end else begin
        mem_ack = 1'b0;
        req_cnt = 0;
      end
    end
  end

  // traffic monitor
  initial begin
    rd_cnt = 0; wr_cnt = 0; overlap = 0;
    last_rd_addr = '0; last_wr_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mem_rden && mem_wren) overlap++;
      if (mem_ack && mem_rden) begin
        rd_cnt++;
        last_rd_addr = mem_address;
      end
      if (mem_ack && mem_wren) begin
        wr_cnt++;
        wr_log.push_back(mem_address);
        last_wr_data = mem_writedata;
      end
    end
  end

  task automatic do_access(input logic [31:0] a, input logic wr, input logic [127:0] wd,
                           input logic [15:0] be, output logic [31:0] rd, output int misses);
    int n;
    @(negedge clk);
    bus_address = a; bus_wren = wr; bus_writedata = wd; bus_byteen = be; bus_en = 1'b1;
    @(negedge clk);
    bus_en = 1'b0;
    #1;
    misses = 0;
    n = 0;
    while (!cache_hit && n < 200) begin
      if (cache_miss) misses++;
      @(negedge clk);
      #1;
      n++;
    end
    chk("access_timeout", 128'(n >= 200), 128'd0);
    rd = bus_readdata;
  endtask

  initial begin
    logic [31:0] rd;
    int miss;
    int rd0, wr0, n;

    n_cmp = 0; n_bad = 0; ack_en = 1'b1;
    resetn = 1'b0; bus_address = '0; bus_en = 1'b0; bus_wren = 1'b0;
    bus_writedata = '0; bus_byteen = '0; bus_flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wait", 128'(bus_wait), 128'd0);
    chk("rst_rden", 128'(mem_rden), 128'd0);
    chk("rst_wren", 128'(mem_wren), 128'd0);
    chk("rst_hit",  128'(cache_hit), 128'd0);
    chk("rst_miss", 128'(cache_miss), 128'd0);
    chk("rst_fdone", 128'(bus_flushdone), 128'd0);
    resetn = 1'b1;

    // cold read miss, fill, replay hit
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_access(32'h100, 1'b0, '0, '0, rd, miss);
    chk("cold_miss", 128'(miss), 128'd1);
    chk("cold_fills", 128'(rd_cnt - rd0), 128'd1);
    chk("cold_fill_addr", 128'(last_rd_addr), 128'h100);
    chk("cold_no_wr", 128'(wr_cnt - wr0), 128'd0);
    chk("cold_word0", 128'(rd), 128'h100);
    chk("cold_line", bus_readdata_line, 128'h00000103_00000102_00000101_00000100);

    // write hit on word 1, read it back
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_access(32'h104, 1'b1, 128'h00000000_00000000_DEADBEEF_00000000, 16'h00F0, rd, miss);
    chk("wr_hit_miss", 128'(miss), 128'd0);
    do_access(32'h104, 1'b0, '0, '0, rd, miss);
    chk("rd104_miss", 128'(miss), 128'd0);
    chk("rd104_data", 128'(rd), 128'hDEADBEEF);
    do_access(32'h108, 1'b0, '0, '0, rd, miss);
    chk("rd108_data", 128'(rd), 128'h102);
    chk("wr_hit_no_traffic", 128'((rd_cnt - rd0) + (wr_cnt - wr0)), 128'd0);

    // back-to-back hits
    @(negedge clk);
    bus_address = 32'h100; bus_wren = 1'b0; bus_en = 1'b1;
    @(negedge clk);
    bus_address = 32'h108;
    #1;
    chk("b2b_hit0", 128'(cache_hit), 128'd1);
    chk("b2b_rd0", 128'(bus_readdata), 128'h100);
    @(negedge clk);
    bus_en = 1'b0;
    #1;
    chk("b2b_hit1", 128'(cache_hit), 128'd1);
    chk("b2b_rd1", 128'(bus_readdata), 128'h102);
    chk("b2b_wait", 128'(bus_wait), 128'd0);

    // second way fill, then eviction of the LRU dirty way
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_access(32'h2100, 1'b0, '0, '0, rd, miss);
    chk("w1_miss", 128'(miss), 128'd1);
    chk("w1_no_evict", 128'(wr_cnt - wr0), 128'd0);
    chk("w1_data", 128'(rd), 128'h2100);
    wr0 = wr_cnt;
    do_access(32'h4100, 1'b0, '0, '0, rd, miss);
    chk("ev_miss", 128'(miss), 128'd1);
    chk("ev_count", 128'(wr_cnt - wr0), 128'd1);
    if (wr_log.size() > 0) chk("ev_addr", 128'(wr_log[wr_log.size()-1]), 128'h100);
    chk("ev_data", last_wr_data, 128'h00000103_00000102_DEADBEEF_00000100);
    chk("ev_fill_addr", 128'(last_rd_addr), 128'h4100);
    chk("ev_rd", 128'(rd), 128'h4100);
    do_access(32'h2100, 1'b0, '0, '0, rd, miss);
    chk("w1_kept", 128'(miss), 128'd0);

    // dirty three lines, then flush
    do_access(32'h2100, 1'b1, 128'h0000_0000_0000_0000_0000_0000_CAFE0001, 16'h000F, rd, miss);
    do_access(32'h200,  1'b1, 128'h0000_0000_0000_0000_0000_0000_11111111, 16'h000F, rd, miss);
    chk("d200_miss", 128'(miss), 128'd1);
    do_access(32'h300,  1'b1, 128'h0000_0000_0000_0000_0000_0000_22222222, 16'h000F, rd, miss);
    wr0 = wr_cnt;
    wr_log.delete();
    @(negedge clk);
    bus_flush = 1'b1;
    @(negedge clk);
    bus_flush = 1'b0;
    #1;
    n = 1;
    while (!bus_flushdone && n < 400) begin
      chk("flush_wait", 128'(bus_wait), 128'd1);
      @(negedge clk);
      #1;
      n++;
    end
    chk("flush_cycles", 128'(n), 128'd131);
    @(negedge clk);
    #1;
    chk("flushdone_pulse", 128'(bus_flushdone), 128'd0);
    chk("post_flush_wait", 128'(bus_wait), 128'd0);
    chk("flush_wr_count", 128'(wr_cnt - wr0), 128'd3);
    if (wr_log.size() == 3) begin
      chk("flush_wb0", 128'(wr_log[0]), 128'h2100);
      chk("flush_wb1", 128'(wr_log[1]), 128'h200);
      chk("flush_wb2", 128'(wr_log[2]), 128'h300);
    end
    do_access(32'h2100, 1'b0, '0, '0, rd, miss);
    chk("pf_miss_2100", 128'(miss), 128'd1);
    chk("pf_data_2100", 128'(rd), 128'hCAFE0001);
    do_access(32'h4100, 1'b0, '0, '0, rd, miss);
    chk("pf_miss_4100", 128'(miss), 128'd1);
    do_access(32'h300, 1'b0, '0, '0, rd, miss);
    chk("pf_miss_300", 128'(miss), 128'd1);
    chk("pf_data_300", 128'(rd), 128'h22222222);

    // reset during a fill with ack withheld
    ack_en = 1'b0;
    @(negedge clk);
    bus_address = 32'h500; bus_wren = 1'b0; bus_en = 1'b1;
    @(negedge clk);
    bus_en = 1'b0;
    #1;
    n = 0;
    while (!mem_rden && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_fill_req", 128'(mem_rden), 128'd1);
    chk("rst_fill_addr", 128'(mem_address), 128'h500);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_rden", 128'(mem_rden), 128'd0);
    chk("rst_mid_wait", 128'(bus_wait), 128'd0);
    resetn = 1'b1;
    ack_en = 1'b1;
    do_access(32'h500, 1'b0, '0, '0, rd, miss);
    chk("reread_miss", 128'(miss), 128'd1);
    chk("reread_data", 128'(rd), 128'h500);

    chk("rd_wr_overlap", 128'(overlap), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_dcache_sa.md
MEM_DCACHE_SA -- requirements
Module: mem_dcache_sa

Interface
REQ-001 SHALL have parameter LOG2CACHELINESIZE, default 7, line size in bits as log2 (line = 2**P bits, minimum 5).
REQ-002 SHALL have parameter LOG2CACHEDEPTH, default 6, number of sets as log2.
REQ-003 SHALL have parameter LOG2NUMWAYS, default 1, associativity as log2 (0 = direct-mapped, 1 = 2-way, 2 = 4-way).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-006 SHALL have port bus_address, input, 32, byte address; held stable while bus_wait=1.
REQ-007 SHALL have port bus_en, input, 1, access request.
REQ-008 SHALL have port bus_wren, input, 1, write qualifier for bus_en.
REQ-009 SHALL have port bus_writedata, input, LINE, full-line write data.
REQ-010 SHALL have port bus_byteen, input, LINE/8, per-byte write enables.
REQ-011 SHALL have port bus_readdata, output, 32, word selected by bus_address[LOG2CACHELINESIZE-4:2].
REQ-012 SHALL have port bus_readdata_line, output, LINE, whole hit line.
REQ-013 SHALL have port bus_wait, output, 1, stall.
REQ-014 SHALL have port bus_flush, input, 1, one-cycle flush request.
REQ-015 SHALL have port bus_flushdone, output, 1, one-cycle flush completion pulse.
REQ-016 SHALL have ports mem_address (output, 32), mem_writedata (output, LINE), mem_readdata (input, LINE), mem_rden (output, 1), mem_wren (output, 1), mem_ack (input, 1); memory request/ack handshake.
REQ-017 SHALL have ports cache_hit and cache_miss, output, 1 each, one-cycle event strobes.

Function
REQ-018 Address split: offset = low LOG2CACHELINESIZE-3 bits; index = next LOG2CACHEDEPTH bits; tag = remaining upper bits.
REQ-019 SHALL run an FSM with states IDLE, LOOKUP, EVICT, FILL, FLUSH.
REQ-020 IDLE with bus_en=1 SHALL go to LOOKUP and register the address; bus_wait=0 in IDLE.
REQ-021 LOOKUP hit (valid and tag match in exactly one way) SHALL set bus_readdata/bus_readdata_line combinationally that cycle, pulse cache_hit, keep bus_wait=0, mark the hit way MRU, and return to IDLE, or re-enter LOOKUP if bus_en=1.
REQ-022 Write hit SHALL merge bus_writedata under bus_byteen into the line and set dirty in the same cycle; hit-to-hit throughput is 1 access/cycle.
REQ-023 LOOKUP miss SHALL pulse cache_miss, assert bus_wait, and select a victim: lowest-numbered invalid way, else the pseudo-LRU way (tree PLRU; single bit for 2-way; ignored when direct-mapped).
REQ-024 Victim valid and dirty SHALL go to EVICT; otherwise SHALL go to FILL.
REQ-025 EVICT SHALL hold mem_wren=1 with mem_address={victim tag,index,0s} and mem_writedata=victim line until the cycle mem_ack=1, then go to FILL.
REQ-026 FILL SHALL hold mem_rden=1 with mem_address={request tag,index,0s} until mem_ack=1; that cycle SHALL write mem_readdata to the victim way, set valid=1, dirty=0, and return to LOOKUP (replay yields a hit).
REQ-027 mem_rden and mem_wren SHALL never be 1 together; request outputs SHALL stay stable until acked.
REQ-028 bus_flush in IDLE SHALL enter FLUSH; bus_flush in any other state SHALL be latched and serviced on the next return to IDLE, ahead of bus_en.
REQ-029 FLUSH SHALL walk entries (set 0..2**LOG2CACHEDEPTH-1, way 0..NUMWAYS-1), at 1 cycle per clean entry; each dirty entry SHALL be written back with the EVICT handshake; every entry SHALL end valid=0, dirty=0.
REQ-030 FLUSH SHALL assert bus_wait throughout and pulse bus_flushdone for 1 cycle when the last entry completes, then go to IDLE.
REQ-031 mem_ack SHALL be ignored outside EVICT, FILL and a FLUSH write-back.

Reset
REQ-032 resetn=0 SHALL force IDLE, clear all valid, dirty and PLRU bits, clear the flush latch, and drive mem_rden=0, mem_wren=0, bus_wait=0, cache_hit=0, cache_miss=0, bus_flushdone=0.
REQ-033 Reset mid-EVICT/FILL/FLUSH SHALL abandon the transaction; no partial line SHALL be left valid.

Structure
REQ-034 FSM state encoding and the address field width constants SHALL live in shared package mem_cache_pkg.
REQ-035 PLRU update and victim selection SHALL be sub-module mem_plru, parametrised by LOG2NUMWAYS.

Verification
REQ-036 Defaults; read 0x100 cold -> cache_miss, FILL at 0x100, ack; replay -> cache_hit, bus_readdata = word 0 of the fill.
REQ-037 Write 0x104 byteen=0x00F0 data 0xDEADBEEF; read 0x104 -> 0xDEADBEEF in the LOOKUP cycle, no memory traffic.
REQ-038 Dirty 0x100; fill 0x2100 (same set, way1); access 0x4100 -> EVICT of 0x100 (way0, LRU), then FILL of 0x4100.
REQ-039 Dirty 3 lines, pulse bus_flush -> exactly 3 mem_wren transactions, bus_flushdone after 128 entries; all next reads miss.
REQ-040 resetn=0 during FILL with ack withheld -> mem_rden=0 the next cycle; a reread of the same address misses.
